insight_hart_0_d_msg_tracker: RTL and testbench
===============================================

Name: insight_hart_0_d_msg_tracker

Overview:
- Passive consumer of hart 0's TileLink D-channel Insight probe signals; sits directly downstream of the D-channel probe interface.
- Reassembles D beats into whole messages and checks burst consistency.
- Pushes one summary record per message into a small FIFO, which the Insight trace packetiser drains over ready/valid.
- Never drives the D channel. It only observes d_valid & d_ready.

Parameters:
- DEPTH, 4, record FIFO entries (power of two, >=2)
- MAX_SIZE, 6, largest legal log2(bytes) for data messages (64 B = 8 beats of 64 bits)

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- d_valid  in  1  probed D valid
- d_ready  in  1  probed D ready
- d_opcode  in  3  probed opcode
- d_param  in  2  probed param
- d_size  in  4  probed log2 size
- d_source  in  3  probed source
- d_sink  in  1  probed sink
- d_denied  in  1  probed denied
- d_corrupt  in  1  probed corrupt
- d_data  in  64  probed data
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_opcode/rec_param/rec_size/rec_source/rec_sink  out  3/2/4/3/1  fields captured from the message's first beat
- rec_denied  out  1  OR of denied over all beats
- rec_corrupt  out  1  OR of corrupt over all beats
- rec_beats  out  MAX_SIZE-2  beats observed
- rec_sig  out  64  XOR of d_data over all beats
- rec_err  out  1  message truncated or illegal size
- clear  in  1  synchronous clear of counters and stickies
- msg_count  out  32  records pushed; wraps
- drop_count  out  16  records dropped on full FIFO; saturates at 0xFFFF
- overflow_sticky  out  1  set on any drop
- proto_err  out  1  one-cycle pulse on protocol violation
- proto_err_sticky  out  1  held copy of proto_err

Behaviour:
- Reset (async, reset_n=0): FIFO empty, rec_valid=0, all rec_* = 0, counters 0, stickies 0, proto_err=0, FSM=IDLE. The FSM returns to IDLE immediately, even mid-burst; the partial message is discarded.
- Beat fire = d_valid & d_ready. No other input has effect.
- Data-bearing opcodes: 1 (AccessAckData) and 5 (GrantData).
- Expected beat count:
  - 1 if the opcode is not data-bearing, or if d_size <= 3.
  - Otherwise 1 << (d_size - 3).
- Illegal size: a data-bearing opcode with d_size > MAX_SIZE. The beat closes immediately as a single-beat record with rec_err=1, and proto_err pulses.
- FSM IDLE, on fire:
  - If expected beats = 1, push a record built from this beat.
  - Otherwise latch opcode/param/size/source/sink, start denied/corrupt ORs and sig = d_data, set beat counter = 1, and go to BURST.
- FSM BURST, on fire:
  - Mismatch: if d_opcode, d_size or d_source differs from the latched value, push the accumulated record with rec_err=1, pulse proto_err, drop the offending beat (not recorded) and go to IDLE.
  - Otherwise OR in denied/corrupt, XOR in data, and increment the counter.
  - When the counter reaches the expected count, push the record (rec_beats = expected) and go to IDLE.
- Record latency: rec_valid rises the cycle after the final beat fire, provided the FIFO was empty.
- FIFO:
  - At most one push per cycle; pop on rec_valid & rec_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot, so no drop occurs.
  - Full with no pop: the record is dropped, drop_count increments (saturating) and overflow_sticky is set. msg_count does not increment for drops.
  - Output fields are stable while rec_valid=1 and rec_ready=0.
- clear:
  - Zeroes msg_count, drop_count, overflow_sticky and proto_err_sticky. The FIFO and FSM are unaffected.
  - If clear coincides with an increment or set, clear wins.
- proto_err_sticky sets on any proto_err pulse and holds until clear or reset.

Test Plan:
- Single-beat AccessAck (opcode 0, size 2, source 5, denied=1), rec_ready=1:
  - record opcode 0, beats 1, denied 1, err 0, sig = beat data, rec_valid high 1 cycle after the fire; msg_count = 1.
- AccessAckData, size 6, source 3, 8 beats with data 1..8 and corrupt on beat 4 only, d_ready toggled to make gaps:
  - one record, beats 8, corrupt 1, sig = XOR(1..8) = 0x8, err 0.
- Burst size 5 (4 beats) where beat 3 carries source 2 instead of 3:
  - record beats 2, err 1; proto_err pulses once and the sticky is set; the 4th beat then starts a fresh burst in IDLE.
- rec_ready=0, send 5 single-beat messages (DEPTH=4):
  - 4 records held, drop_count = 1, overflow_sticky = 1; assert clear, then drop_count = 0, overflow_sticky = 0, FIFO still holds 4.
- GrantData, size 8 (illegal, >6):
  - single record, err 1, beats 1, proto_err pulse.
- reset_n low during beat 2 of an 8-beat burst:
  - all outputs 0 immediately; after release, a new single-beat message produces a correct record with beats 1.

Source files
------------

// File: rtl/insight_hart_0_d_msg_tracker_if.sv
// insight_hart_0_d_msg_tracker_if: D-channel probe signals plus the record drain channel
interface insight_hart_0_d_msg_tracker_if #(parameter int MAX_SIZE = 6);
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [3:0]          d_size;
  logic [2:0]          d_source;
  logic                d_sink;
  logic                d_denied;
  logic                d_corrupt;
  logic [63:0]         d_data;
  logic                rec_valid;
  logic                rec_ready;
  logic [2:0]          rec_opcode;
  logic [1:0]          rec_param;
  logic [3:0]          rec_size;
  logic [2:0]          rec_source;
  logic                rec_sink;
  logic                rec_denied;
  logic                rec_corrupt;
  logic [MAX_SIZE-3:0] rec_beats;
  logic [63:0]         rec_sig;
  logic                rec_err;
  modport master (
    output d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data, rec_ready,
    input  rec_valid, rec_opcode, rec_param, rec_size, rec_source, rec_sink, rec_denied, rec_corrupt, rec_beats,
           rec_sig, rec_err
  );
  modport slave (
    input  d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data, rec_ready,
    output rec_valid, rec_opcode, rec_param, rec_size, rec_source, rec_sink, rec_denied, rec_corrupt, rec_beats,
           rec_sig, rec_err
  );
endinterface

// File: rtl/insight_hart_0_d_msg_tracker.sv
// insight_hart_0_d_msg_tracker: reassembles observed D beats into message records queued for the trace packetiser
// Ports: clock/reset_n (async active-low); bus = probe inputs + rec_* ready/valid record drain;
// clear zeroes msg_count/drop_count/overflow_sticky/proto_err_sticky; proto_err pulses on protocol violations.
module insight_hart_0_d_msg_tracker #(
  parameter int DEPTH    = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic                          clock,
  input  logic                          reset_n,
  insight_hart_0_d_msg_tracker_if.slave bus,
  input  logic                          clear,
  output logic [31:0]                   msg_count,
  output logic [15:0]                   drop_count,
  output logic                          overflow_sticky,
  output logic                          proto_err,
  output logic                          proto_err_sticky
);
  localparam int BW = MAX_SIZE - 2;
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]    opcode;
    logic [1:0]    param;
    logic [3:0]    size;
    logic [2:0]    source;
    logic          sink;
    logic          denied;
    logic          corrupt;
    logic [BW-1:0] beats;
    logic [63:0]   sig;
    logic          err;
  } rec_t;
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state_q, state_d;
  rec_t          acc_q, acc_d, beat, rec, out;
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [BW-1:0] exp_q, exp_d, exp_n;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   msg_count_q, msg_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          ovf_q, ovf_d, perr_q, perr_sticky_q, perr_sticky_d;
  logic          fire, is_data, illegal, mismatch, last, push, perr, valid, pop, full, wr, drop;
  assign fire     = bus.d_valid & bus.d_ready;
  assign is_data  = bus.d_opcode == 3'd1 || bus.d_opcode == 3'd5;
  assign illegal  = is_data && bus.d_size > 4'(MAX_SIZE);
  // Illegal sizes close as a single beat rather than waiting for a burst of unknown length
  assign exp_n    = (!is_data || bus.d_size <= 4'd3 || illegal) ? BW'(1) : BW'(1) << (bus.d_size - 4'd3);
  assign mismatch = bus.d_opcode != acc_q.opcode || bus.d_size != acc_q.size || bus.d_source != acc_q.source;
  assign last     = acc_q.beats + BW'(1) == exp_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (fire && state_q == IDLE && exp_n != BW'(1)) state_d = BURST;
    if (fire && state_q == BURST && (mismatch || last)) state_d = IDLE;
  end
  always_comb begin
    beat  = '{opcode: bus.d_opcode, param: bus.d_param, size: bus.d_size, source: bus.d_source, sink: bus.d_sink,
              denied: bus.d_denied, corrupt: bus.d_corrupt, beats: BW'(1), sig: bus.d_data, err: illegal};
    acc_d = acc_q;
    exp_d = exp_q;
    rec   = beat;
    push  = 1'b0;
    perr  = 1'b0;
    if (fire && state_q == IDLE) begin
      if (exp_n == BW'(1)) begin
        push = 1'b1;
        perr = illegal;
      end else begin
        acc_d = beat;
        exp_d = exp_n;
      end
    end else if (fire) begin
      if (mismatch) begin
        // The offending beat is dropped; only what was accumulated so far is reported
        rec     = acc_q;
        rec.err = 1'b1;
        push    = 1'b1;
        perr    = 1'b1;
      end else begin
        acc_d.denied  = acc_q.denied | bus.d_denied;
        acc_d.corrupt = acc_q.corrupt | bus.d_corrupt;
        acc_d.sig     = acc_q.sig ^ bus.d_data;
        acc_d.beats   = acc_q.beats + BW'(1);
        rec           = acc_d;
        push          = last;
      end
    end
  end
  assign valid = cnt_q != '0;
  assign pop   = valid & bus.rec_ready;
  assign full  = cnt_q == (AW + 1)'(DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = rec;
    wp_d          = wp_q + AW'(wr);
    rp_d          = rp_q + AW'(pop);
    cnt_d         = cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    msg_count_d   = clear ? '0 : msg_count_q + 32'(wr);
    drop_count_d  = clear ? '0 : drop_count_q + 16'(drop && drop_count_q != 16'hffff);
    ovf_d         = ~clear & (ovf_q | drop);
    perr_sticky_d = ~clear & (perr_sticky_q | perr);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      acc_q         <= '0;
      exp_q         <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      msg_count_q   <= '0;
      drop_count_q  <= '0;
      ovf_q         <= 1'b0;
      perr_q        <= 1'b0;
      perr_sticky_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      acc_q         <= acc_d;
      exp_q         <= exp_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      cnt_q         <= cnt_d;
      msg_count_q   <= msg_count_d;
      drop_count_q  <= drop_count_d;
      ovf_q         <= ovf_d;
      perr_q        <= perr;
      perr_sticky_q <= perr_sticky_d;
    end
  end
  assign out             = valid ? mem_q[rp_q] : '0;
  assign bus.rec_valid   = valid;
  assign bus.rec_opcode  = out.opcode;
  assign bus.rec_param   = out.param;
  assign bus.rec_size    = out.size;
  assign bus.rec_source  = out.source;
  assign bus.rec_sink    = out.sink;
  assign bus.rec_denied  = out.denied;
  assign bus.rec_corrupt = out.corrupt;
  assign bus.rec_beats   = out.beats;
  assign bus.rec_sig     = out.sig;
  assign bus.rec_err     = out.err;
  assign msg_count        = msg_count_q;
  assign drop_count       = drop_count_q;
  assign overflow_sticky  = ovf_q;
  assign proto_err        = perr_q;
  assign proto_err_sticky = perr_sticky_q;
endmodule

// File: tb/tb_insight_hart_0_d_msg_tracker.sv
// tb_insight_hart_0_d_msg_tracker: directed stimulus with a record scoreboard and counter checks
module tb_insight_hart_0_d_msg_tracker;
  localparam int RW = 84;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic [31:0] msg_count;
  logic [15:0] drop_count;
  logic ovf, proto_err, sticky;
  int checks = 0, errors = 0;
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] got, want;
  insight_hart_0_d_msg_tracker_if bus ();
  insight_hart_0_d_msg_tracker dut (
    .clock(clk), .reset_n(reset_n), .bus(bus), .clear(clear), .msg_count(msg_count), .drop_count(drop_count),
    .overflow_sticky(ovf), .proto_err(proto_err), .proto_err_sticky(sticky)
  );
  always #5 clk = ~clk;
  function automatic logic [RW-1:0] mk(logic [2:0] op, logic [1:0] pa, logic [3:0] sz, logic [2:0] src, logic sk,
                                       logic dn, logic cr, logic [3:0] bt, logic [63:0] sig, logic er);
    return {op, pa, sz, src, sk, dn, cr, bt, sig, er};
  endfunction
  task automatic chk(string n, logic [63:0] g, logic [63:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, g, w);
    end
  endtask
  task automatic beat(logic [2:0] op, logic [1:0] pa, logic [3:0] sz, logic [2:0] src, logic sk, logic dn,
                      logic cr, logic [63:0] data, int stall);
    bus.d_opcode = op; bus.d_param = pa; bus.d_size = sz; bus.d_source = src; bus.d_sink = sk;
    bus.d_denied = dn; bus.d_corrupt = cr; bus.d_data = data;
    bus.d_valid = 1'b1; bus.d_ready = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    bus.d_valid = 1'b0; bus.d_ready = 1'b0;
  endtask
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
    chk("drain", 64'(exp_q.size()), 0);
  endtask
  always @(negedge clk) begin
    if (bus.rec_valid && bus.rec_ready) begin
      got = {bus.rec_opcode, bus.rec_param, bus.rec_size, bus.rec_source, bus.rec_sink, bus.rec_denied,
             bus.rec_corrupt, bus.rec_beats, bus.rec_sig, bus.rec_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got %h expected none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL record: got %h expected %h", got, want);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bus.d_valid = 0; bus.d_ready = 0; bus.d_opcode = 0; bus.d_param = 0; bus.d_size = 0; bus.d_source = 0;
    bus.d_sink = 0; bus.d_denied = 0; bus.d_corrupt = 0; bus.d_data = 0; bus.rec_ready = 1;
    cyc(2);
    chk("rst_valid", bus.rec_valid, 0);
    chk("rst_msg", msg_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_sticky", sticky, 0);
    reset_n = 1'b1;
    cyc(1);
    // single-beat AccessAck
    exp_q.push_back(mk(0, 0, 2, 5, 0, 1, 0, 1, 64'hdeadbeef_00000001, 0));
    beat(0, 0, 2, 5, 0, 1, 0, 64'hdeadbeef_00000001, 0);
    chk("t1_latency", bus.rec_valid, 1);
    chk("t1_msg", msg_count, 1);
    chk("t1_perr", proto_err, 0);
    drain();
    // 8-beat AccessAckData with gaps, corrupt on beat 4
    exp_q.push_back(mk(1, 0, 6, 3, 0, 0, 1, 8, 64'h8, 0));
    for (int i = 1; i <= 8; i++) begin
      beat(1, 0, 6, 3, 0, 0, i == 4, 64'(i), (i % 2 == 0) ? 1 : 0);
      if (i == 4) chk("t2_mid_valid", bus.rec_valid, 0);
    end
    drain();
    chk("t2_msg", msg_count, 2);
    // source mismatch on beat 3 of a 4-beat burst
    exp_q.push_back(mk(1, 0, 5, 3, 0, 0, 0, 2, 64'h30, 1));
    exp_q.push_back(mk(1, 0, 5, 3, 0, 0, 0, 4, 64'h0, 0));
    beat(1, 0, 5, 3, 0, 0, 0, 64'h10, 0);
    beat(1, 0, 5, 3, 0, 0, 0, 64'h20, 0);
    beat(1, 0, 5, 2, 0, 0, 0, 64'h30, 0);
    chk("t3_perr_pulse", proto_err, 1);
    chk("t3_sticky", sticky, 1);
    beat(1, 0, 5, 3, 0, 0, 0, 64'h40, 0);
    chk("t3_perr_end", proto_err, 0);
    beat(1, 0, 5, 3, 0, 0, 0, 64'h50, 0);
    beat(1, 0, 5, 3, 0, 0, 0, 64'h60, 0);
    beat(1, 0, 5, 3, 0, 0, 0, 64'h70, 0);
    drain();
    chk("t3_msg", msg_count, 4);
    // overflow with rec_ready low
    bus.rec_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(mk(0, 0, 0, 3'(i), 0, 0, 0, 1, 64'(i), 0));
      beat(0, 0, 0, 3'(i), 0, 0, 0, 64'(i), 0);
    end
    chk("t4_valid", bus.rec_valid, 1);
    chk("t4_drop", drop_count, 1);
    chk("t4_ovf", ovf, 1);
    chk("t4_msg", msg_count, 8);
    cyc(2);
    chk("t4_stable", bus.rec_sig, 1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t4_clr_drop", drop_count, 0);
    chk("t4_clr_ovf", ovf, 0);
    chk("t4_clr_msg", msg_count, 0);
    chk("t4_clr_sticky", sticky, 0);
    chk("t4_still_full", bus.rec_valid, 1);
    // push and pop together while full
    exp_q.push_back(mk(0, 0, 0, 6, 0, 0, 0, 1, 64'h6, 0));
    bus.rec_ready = 1'b1;
    beat(0, 0, 0, 6, 0, 0, 0, 64'h6, 0);
    chk("t4_fullpp_drop", drop_count, 0);
    chk("t4_fullpp_msg", msg_count, 1);
    drain();
    cyc(1);
    chk("t4_empty", bus.rec_valid, 0);
    // GrantData with illegal size
    exp_q.push_back(mk(5, 0, 8, 1, 0, 0, 0, 1, 64'habc, 1));
    beat(5, 0, 8, 1, 0, 0, 0, 64'habc, 0);
    chk("t5_perr", proto_err, 1);
    chk("t5_sticky", sticky, 1);
    cyc(1);
    chk("t5_perr_end", proto_err, 0);
    drain();
    chk("t5_msg", msg_count, 2);
    // reset mid-burst
    beat(1, 0, 6, 0, 0, 0, 0, 64'h11, 0);
    bus.d_data = 64'h22; bus.d_valid = 1'b1; bus.d_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", bus.rec_valid, 0);
    chk("t6_msg", msg_count, 0);
    chk("t6_sticky", sticky, 0);
    chk("t6_sig", bus.rec_sig, 0);
    bus.d_valid = 1'b0; bus.d_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1);
    exp_q.push_back(mk(0, 0, 3, 4, 1, 0, 0, 1, 64'h55, 0));
    beat(0, 0, 3, 4, 1, 0, 0, 64'h55, 0);
    chk("t6_msg_after", msg_count, 1);
    drain();
    chk("t6_perr", sticky, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
